fetch_seq_ctrl: RTL and testbench
=================================

Name: fetch_seq_ctrl

Overview:
Fetch sequencer that owns the PC register and drives the branch prediction unit.
- Arbitrates each cycle between trap redirects, BPU corrections and predictions, pipeline stalls, instruction-memory wait states and sequential PC+4.
- Generates pc_en for the BPU and the IF/ID register, plus the fetch-valid and flush controls.
- Sits between the BPU, the instruction memory port and the hazard/trap logic.

Parameters:
PC_WIDTH, 32, PC and address width.
RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
FLUSH_CYCLES, 2, bubble cycles inserted after a trap redirect (≥1).
CNT_WIDTH, 16, width of the performance counters.

Ports:
clk  in  1  clock, posedge.
nrst  in  1  synchronous, active-low reset.
imem_ready  in  1  instruction memory can accept a fetch this cycle.
stall_id  in  1  hazard unit requests a fetch hold.
trap_req  in  1  trap/exception redirect request, single-cycle pulse.
trap_vec  in  PC_WIDTH  trap target address.
bpu_mux_sel  in  1  BPU selects bpu_npc instead of PC+4.
bpu_npc  in  PC_WIDTH  BPU next-PC.
bpu_chng2nop  in  1  BPU correction (misprediction, aliasing, or first jal target).
pc  out  PC_WIDTH  current fetch PC; drives BPU pc and memory address.
pcplf  out  PC_WIDTH  pc+4, modulo 2^PC_WIDTH; drives BPU pcplf.
pc_en  out  1  PC/pipeline advance enable; drives BPU pc_en.
fetch_valid  out  1  fetched instruction in IF is valid.
flush_if  out  1  convert the IF/ID instruction to NOP.
redirect_cnt  out  CNT_WIDTH  count of accepted BPU corrections; saturating.
trap_cnt  out  CNT_WIDTH  count of accepted traps; saturating.

Behaviour:
Reset (nrst=0 at posedge):
- pc=RESET_VECTOR, state=BOOT, pending redirect cleared, counters 0.
- Outputs pc_en=0, fetch_valid=0, flush_if=0.
- Reset has priority over everything, including mid-flush or mid-wait.

States:
- BOOT: exactly 1 cycle, all enables 0, then RUN.
- RUN: normal fetch.
- WAIT_MEM: memory busy.
- FLUSH: post-trap bubbles.

Combinational outputs:
- pc_en = (state==RUN) & imem_ready & ~stall_id & ~trap_req.
- fetch_valid = pc_en.
- flush_if = 1 in FLUSH; else trap_req | bpu_chng2nop.

RUN, next PC in priority order:
1. trap_req: pc←trap_vec, clear pending, load flush counter with FLUSH_CYCLES-1, go FLUSH, trap_cnt++.
2. bpu_chng2nop & pc_en: pc←bpu_npc, redirect_cnt++.
3. bpu_chng2nop & ~pc_en (stall or memory busy): latch pend_pc←bpu_npc, pend_valid←1, redirect_cnt++ once. Further chng2nop pulses while pend_valid=1 overwrite pend_pc but do not increment the counter.
4. pc_en & pend_valid: pc←pend_pc, clear pending.
5. pc_en: pc ← bpu_mux_sel ? bpu_npc : pcplf.
6. Otherwise hold pc.

Other transitions:
- RUN & ~imem_ready & ~trap_req → WAIT_MEM; pc held.
- WAIT_MEM → RUN when imem_ready=1. trap_req in WAIT_MEM is handled as in RUN: go FLUSH.
- FLUSH: counter decrements each cycle; at 0 go RUN. trap_req during FLUSH reloads pc and the counter (restart).
- The pending redirect is applied on the first pc_en cycle after returning to RUN.

Simultaneous events:
- trap_req beats everything.
- A stall beats a BPU prediction; bpu_mux_sel is ignored when pc_en=0.
- A pending redirect beats bpu_mux_sel.

Arithmetic: pcplf wraps, so pc=32'hFFFF_FFFC gives pcplf=0. Counters stick at all-ones.

Test Plan:
1. Reset, then imem_ready=1 with no events for 4 cycles → pc 0,0,4,8,12 (BOOT cycle holds 0); pc_en=0 in the first cycle.
2. At pc=0x10, bpu_mux_sel=1, bpu_npc=0x80 → next pc=0x80, redirect_cnt unchanged.
3. stall_id=1 while bpu_chng2nop=1, bpu_npc=0x40, then stall released two cycles later → pc held, then pc=0x40; redirect_cnt=1; flush_if=1 in the chng2nop cycle.
4. trap_req with trap_vec=0x200, FLUSH_CYCLES=2 → pc=0x200, two cycles with flush_if=1 and pc_en=0, then 0x204; trap_cnt=1. A second trap at 0x300 during flush restarts the 2-cycle flush.
5. imem_ready=0 for 3 cycles at pc=0x20 → WAIT_MEM, pc held at 0x20, fetch_valid=0; resumes 0x24 after ready.
6. trap_req and bpu_chng2nop in the same cycle → pc=trap_vec, redirect_cnt unchanged. nrst asserted mid-FLUSH → pc=RESET_VECTOR, BOOT next cycle.

Source files
------------

// File: rtl/fetch_seq_if.sv
// Fetch sequencer bundle: the signals between the sequencer and the
// instruction memory, BPU and hazard/trap logic.
interface fetch_seq_if #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
) ();
  logic                 imem_ready;
  logic                 stall_id;
  logic                 trap_req;
  logic [PC_WIDTH-1:0]  trap_vec;
  logic                 bpu_mux_sel;
  logic [PC_WIDTH-1:0]  bpu_npc;
  logic                 bpu_chng2nop;
  logic [PC_WIDTH-1:0]  pc;
  logic [PC_WIDTH-1:0]  pcplf;
  logic                 pc_en;
  logic                 fetch_valid;
  logic                 flush_if;
  logic [CNT_WIDTH-1:0] redirect_cnt;
  logic [CNT_WIDTH-1:0] trap_cnt;

  modport master (
    input  imem_ready, stall_id, trap_req, trap_vec,
           bpu_mux_sel, bpu_npc, bpu_chng2nop,
    output pc, pcplf, pc_en, fetch_valid, flush_if, redirect_cnt, trap_cnt
  );

  modport slave (
    output imem_ready, stall_id, trap_req, trap_vec,
           bpu_mux_sel, bpu_npc, bpu_chng2nop,
    input  pc, pcplf, pc_en, fetch_valid, flush_if, redirect_cnt, trap_cnt
  );
endinterface

// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencer: owns the PC, arbitrates trap / BPU / stall / memory-wait
// redirects and produces the pipeline advance and flush controls.
module fetch_seq_ctrl #(
  parameter int                    PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = '0,
  parameter int                    FLUSH_CYCLES = 2,
  parameter int                    CNT_WIDTH    = 16
) (
  input  logic       clk,
  input  logic       nrst,
  fetch_seq_if.master bus
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0]      FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_WAIT_MEM, S_FLUSH} state_e;

  state_e               state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [PC_WIDTH-1:0]  pend_pc_q, pend_pc_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [FC_W-1:0]      flush_cnt_q, flush_cnt_d;
  logic [CNT_WIDTH-1:0] redirect_cnt_q, redirect_cnt_d;
  logic [CNT_WIDTH-1:0] trap_cnt_q, trap_cnt_d;
  logic [PC_WIDTH-1:0]  pcplf;
  logic                 pc_en;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign pcplf = pc_q + PC_WIDTH'(4);
  assign pc_en = (state_q == S_RUN) & bus.imem_ready & ~bus.stall_id & ~bus.trap_req;

  // NOTE: every _d gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    pend_pc_d      = pend_pc_q;
    pend_valid_d   = pend_valid_q;
    flush_cnt_d    = flush_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    trap_cnt_d     = trap_cnt_q;

    case (state_q)
      S_BOOT: state_d = S_RUN;

      S_RUN, S_WAIT_MEM: begin
        if (bus.trap_req) begin
          pc_d         = bus.trap_vec;
          pend_valid_d = 1'b0;
          flush_cnt_d  = FLUSH_LOAD;
          trap_cnt_d   = sat_inc(trap_cnt_q);
          state_d      = S_FLUSH;
        end else begin
          if (bus.bpu_chng2nop && pc_en) begin
            pc_d           = bus.bpu_npc;
            pend_valid_d   = 1'b0;
            redirect_cnt_d = sat_inc(redirect_cnt_q);
          end else if (bus.bpu_chng2nop) begin
            // A correction that cannot be taken now is parked; repeats only
            // refresh the target, so one stalled correction counts once.
            pend_pc_d    = bus.bpu_npc;
            pend_valid_d = 1'b1;
            if (!pend_valid_q) redirect_cnt_d = sat_inc(redirect_cnt_q);
          end else if (pc_en && pend_valid_q) begin
            pc_d         = pend_pc_q;
            pend_valid_d = 1'b0;
          end else if (pc_en) begin
            pc_d = bus.bpu_mux_sel ? bus.bpu_npc : pcplf;
          end

          if (state_q == S_RUN && !bus.imem_ready)     state_d = S_WAIT_MEM;
          if (state_q == S_WAIT_MEM && bus.imem_ready) state_d = S_RUN;
        end
      end

      S_FLUSH: begin
        if (bus.trap_req) begin
          pc_d         = bus.trap_vec;
          pend_valid_d = 1'b0;
          flush_cnt_d  = FLUSH_LOAD;
          trap_cnt_d   = sat_inc(trap_cnt_q);
        end else if (flush_cnt_q == '0) begin
          state_d = S_RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - FC_W'(1);
        end
      end

      default: state_d = S_BOOT;
    endcase
  end

  // NOTE: state flops use <= so every flop samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q        <= S_BOOT;
      pc_q           <= RESET_VECTOR;
      pend_valid_q   <= 1'b0;
      flush_cnt_q    <= '0;
      redirect_cnt_q <= '0;
      trap_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      pend_valid_q   <= pend_valid_d;
      flush_cnt_q    <= flush_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
      trap_cnt_q     <= trap_cnt_d;
    end
  end

  // NOTE: pend_pc is payload qualified by pend_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    pend_pc_q <= pend_pc_d;
  end

  assign bus.pc           = pc_q;
  assign bus.pcplf        = pcplf;
  assign bus.pc_en        = pc_en;
  assign bus.fetch_valid  = pc_en;
  assign bus.flush_if     = (state_q == S_FLUSH) ||
                            ((state_q != S_BOOT) && (bus.trap_req || bus.bpu_chng2nop));
  assign bus.redirect_cnt = redirect_cnt_q;
  assign bus.trap_cnt     = trap_cnt_q;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Scoreboard bench for fetch_seq_ctrl: each directed cycle pushes its expected
// outputs; a negedge monitor pops and compares them against the DUT.
module tb_fetch_seq_ctrl;

  logic clk;
  logic nrst;

  fetch_seq_if #(.PC_WIDTH(32), .CNT_WIDTH(4)) bus ();

  fetch_seq_ctrl #(
    .PC_WIDTH    (32),
    .RESET_VECTOR(32'h0000_0000),
    .FLUSH_CYCLES(2),
    .CNT_WIDTH   (4)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus.master)
  );

  typedef struct {
    string       nm;
    logic [31:0] pc;
    logic [31:0] pcplf;
    logic        en;
    logic        fl;
    logic [31:0] rc;
    logic [31:0] tc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      if (bus.pc !== e.pc || bus.pcplf !== e.pcplf || bus.pc_en !== e.en ||
          bus.fetch_valid !== e.en || bus.flush_if !== e.fl ||
          32'(bus.redirect_cnt) !== e.rc || 32'(bus.trap_cnt) !== e.tc) begin
        miscompares++;
        $display("FAIL %s: got pc=%h pcplf=%h pc_en=%b fv=%b flush=%b rc=%0d tc=%0d, want pc=%h pcplf=%h pc_en=%b fv=%b flush=%b rc=%0d tc=%0d",
                 e.nm, bus.pc, bus.pcplf, bus.pc_en, bus.fetch_valid, bus.flush_if,
                 bus.redirect_cnt, bus.trap_cnt,
                 e.pc, e.pcplf, e.en, e.en, e.fl, e.rc, e.tc);
      end
    end
  end

  // Drive one cycle of inputs, queue what the DUT must show during it, advance.
  task automatic step(input string nm, input logic rdy, input logic stl,
                      input logic trp, input logic [31:0] tv, input logic sel,
                      input logic [31:0] npc, input logic chg,
                      input logic [31:0] e_pc, input logic e_en, input logic e_fl,
                      input int e_rc, input int e_tc);
    exp_t e;
    bus.imem_ready   = rdy;
    bus.stall_id     = stl;
    bus.trap_req     = trp;
    bus.trap_vec     = tv;
    bus.bpu_mux_sel  = sel;
    bus.bpu_npc      = npc;
    bus.bpu_chng2nop = chg;
    e.nm    = nm;
    e.pc    = e_pc;
    e.pcplf = e_pc + 32'd4;
    e.en    = e_en;
    e.fl    = e_fl;
    e.rc    = 32'(e_rc);
    e.tc    = 32'(e_tc);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string nm, input logic [31:0] e_pc, input logic e_en,
                      input logic e_fl, input int e_rc, input int e_tc);
    step(nm, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, e_pc, e_en, e_fl, e_rc, e_tc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cur_pc;
    nrst = 1'b0;
    bus.imem_ready = 1'b1; bus.stall_id = 1'b0; bus.trap_req = 1'b0;
    bus.trap_vec = '0; bus.bpu_mux_sel = 1'b0; bus.bpu_npc = '0; bus.bpu_chng2nop = 1'b0;
    @(posedge clk);
    #1;

    // Reset and sequential fetch: BOOT holds 0 for one cycle.
    idle("in_reset", 32'h0, 1'b0, 1'b0, 0, 0);
    nrst = 1'b1;
    idle("boot",     32'h0, 1'b0, 1'b0, 0, 0);
    idle("seq0",     32'h0, 1'b1, 1'b0, 0, 0);
    idle("seq1",     32'h4, 1'b1, 1'b0, 0, 0);
    idle("seq2",     32'h8, 1'b1, 1'b0, 0, 0);
    idle("seq3",     32'hC, 1'b1, 1'b0, 0, 0);

    // BPU prediction does not touch the redirect counter.
    step("bpu_pred", 1, 0, 0, 0, 1, 32'h80, 0, 32'h10, 1, 0, 0, 0);
    idle("after_pred", 32'h80, 1'b1, 1'b0, 0, 0);

    // Correction under stall is parked; stall beats prediction; pending beats mux_sel.
    step("chg_stall",  1, 1, 0, 0, 0, 32'h40,  1, 32'h84, 0, 1, 0, 0);
    step("stall_pred", 1, 1, 0, 0, 1, 32'h999, 0, 32'h84, 0, 0, 1, 0);
    step("pend_apply", 1, 0, 0, 0, 1, 32'h500, 0, 32'h84, 1, 0, 1, 0);
    idle("at_pend", 32'h40, 1'b1, 1'b0, 1, 0);
    step("chg_run",    1, 0, 0, 0, 0, 32'h100, 1, 32'h44, 1, 1, 1, 0);
    idle("at_chg", 32'h100, 1'b1, 1'b0, 2, 0);

    // Repeated corrections while pending overwrite the target, count once.
    step("chg_pend1",  1, 1, 0, 0, 0, 32'h60, 1, 32'h104, 0, 1, 2, 0);
    step("chg_pend2",  1, 1, 0, 0, 0, 32'h70, 1, 32'h104, 0, 1, 3, 0);
    idle("pend2_apply", 32'h104, 1'b1, 1'b0, 3, 0);
    idle("at_pend2",    32'h70,  1'b1, 1'b0, 3, 0);

    // Trap redirect and two flush bubbles.
    step("trap",       1, 0, 1, 32'h200, 0, 0, 0, 32'h74, 0, 1, 3, 0);
    idle("flush_a",   32'h200, 1'b0, 1'b1, 3, 1);
    idle("flush_b",   32'h200, 1'b0, 1'b1, 3, 1);
    idle("post_trap", 32'h200, 1'b1, 1'b0, 3, 1);
    idle("seq_204",   32'h204, 1'b1, 1'b0, 3, 1);

    // A trap during flush restarts it.
    step("trap2",         1, 0, 1, 32'h280, 0, 0, 0, 32'h208, 0, 1, 3, 1);
    idle("flush_c",   32'h280, 1'b0, 1'b1, 3, 2);
    step("trap_in_flush", 1, 0, 1, 32'h300, 0, 0, 0, 32'h280, 0, 1, 3, 2);
    idle("flush_d",   32'h300, 1'b0, 1'b1, 3, 3);
    idle("flush_e",   32'h300, 1'b0, 1'b1, 3, 3);
    idle("post_trap2",32'h300, 1'b1, 1'b0, 3, 3);

    // Memory wait states hold the PC.
    step("mem_busy0", 0, 0, 0, 0, 0, 0, 0, 32'h304, 0, 0, 3, 3);
    step("mem_busy1", 0, 0, 0, 0, 0, 0, 0, 32'h304, 0, 0, 3, 3);
    step("mem_busy2", 0, 0, 0, 0, 0, 0, 0, 32'h304, 0, 0, 3, 3);
    idle("mem_ready",  32'h304, 1'b0, 1'b0, 3, 3);
    idle("mem_resume", 32'h304, 1'b1, 1'b0, 3, 3);
    idle("seq_308",    32'h308, 1'b1, 1'b0, 3, 3);

    // Correction during a memory wait lands after return to RUN.
    step("busy_chg",   0, 0, 0, 0, 0, 32'h600, 1, 32'h30C, 0, 1, 3, 3);
    idle("busy_ready", 32'h30C, 1'b0, 1'b0, 4, 3);
    step("busy_pend",  1, 0, 0, 0, 1, 32'h700, 0, 32'h30C, 1, 0, 4, 3);
    idle("at_600",     32'h600, 1'b1, 1'b0, 4, 3);

    // Trap + correction in WAIT_MEM: trap wins, redirect count unchanged; then PC wrap.
    step("busy3",      0, 0, 0, 0, 0, 0, 0, 32'h604, 0, 0, 4, 3);
    step("trap_wait",  0, 0, 1, 32'hFFFF_FFF8, 0, 32'h900, 1, 32'h604, 0, 1, 4, 3);
    idle("flush_f",    32'hFFFF_FFF8, 1'b0, 1'b1, 4, 4);
    idle("flush_g",    32'hFFFF_FFF8, 1'b0, 1'b1, 4, 4);
    idle("wrap0",      32'hFFFF_FFF8, 1'b1, 1'b0, 4, 4);
    idle("wrap1",      32'hFFFF_FFFC, 1'b1, 1'b0, 4, 4);
    idle("wrap2",      32'h0,         1'b1, 1'b0, 4, 4);

    // Trap + correction in RUN, then reset in the middle of the flush.
    step("trap_chg",   1, 0, 1, 32'h400, 0, 32'h50, 1, 32'h4, 0, 1, 4, 4);
    idle("flush_h",    32'h400, 1'b0, 1'b1, 4, 5);
    nrst = 1'b0;
    idle("rst_flush",  32'h400, 1'b0, 1'b1, 4, 5);
    nrst = 1'b1;
    idle("boot2",      32'h0, 1'b0, 1'b0, 0, 0);
    idle("run2",       32'h0, 1'b1, 1'b0, 0, 0);

    // Redirect counter saturates at all-ones (4-bit instance).
    cur_pc = 32'h4;
    for (int i = 0; i < 18; i++) begin
      step("sat_chg", 1, 0, 0, 0, 0, 32'h1000 + 32'(i) * 32'h10, 1,
           cur_pc, 1, 1, (i > 15) ? 15 : i, 0);
      cur_pc = 32'h1000 + 32'(i) * 32'h10;
    end
    idle("sat_hold", cur_pc, 1'b1, 1'b0, 15, 0);

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
